// File: rtl/inst_queue_if.sv
// Handshake bundle between fetch (in_*) and decode (out_*) around the instruction queue.
// master = producer/consumer side, slave = the queue itself.
interface inst_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst
    );
endinterface

// File: rtl/inst_queue.sv
// In-order {pc, inst} FIFO between fetch and decode with flush on redirect.
// INST_QUEUE_BYPASS_EN: zero-latency pass-through when the queue is empty.
module inst_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    inst_queue_if.slave            q_if,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 2 * XLEN;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] mem_q [DEPTH];

    logic             empty_c;
    logic             full_c;
    logic             enq_c;
    logic             deq_c;
    logic             bypass_c;
    logic [ENT_W-1:0] head_c;

    // Handshake decode and output presentation
    always_comb begin
        empty_c = (count_q == '0);
        full_c  = (count_q == CNT_W'(DEPTH));
        head_c  = mem_q[rd_ptr_q];

        q_if.in_ready  = ~full_c;
        q_if.out_valid = ~empty_c;
        {q_if.out_pc, q_if.out_inst} = empty_c ? '0 : head_c;

`ifdef INST_QUEUE_BYPASS_EN
        // Empty queue forwards fetch straight to decode; a consumed entry is never stored.
        bypass_c = empty_c & ~flush & q_if.in_valid & q_if.out_ready;
        if (empty_c) begin
            q_if.out_valid = q_if.in_valid & ~flush;
            q_if.out_pc    = flush ? '0 : q_if.in_pc;
            q_if.out_inst  = flush ? '0 : q_if.in_inst;
        end
`else
        bypass_c = 1'b0;
`endif

        enq_c = q_if.in_valid & ~full_c & ~flush & ~bypass_c;
        deq_c = q_if.out_ready & ~empty_c & ~flush;
    end

    // Pointer and occupancy next-state; flush discards everything
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (deq_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (enq_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; empty outputs are masked instead
    always_ff @(posedge clk) begin
        if (rst && enq_c) begin
            mem_q[wr_ptr_q] <= {q_if.in_pc, q_if.in_inst};
        end
    end

    assign count = count_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (count_q <= CNT_W'(DEPTH));
            assert (!(deq_c && empty_c));
            assert (!(enq_c && full_c && !deq_c));
        end
    end
`endif
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed vector table, hand sequences, and
// randomized traffic compared against a queue-based reference model.
module tb_inst_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
`ifdef INST_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] count;

    inst_queue_if #(.XLEN(XLEN)) qi ();

    inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .q_if (qi),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] mq[$];

    typedef struct {
        bit          r;
        bit          f;
        bit          iv;
        logic [31:0] pc;
        logic [31:0] inst;
        bit          ordy;
        bit          e_ov;
        bit          e_ir;
        int          e_cnt;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic addv(input bit r, f, iv, input logic [31:0] pc, inst, input bit ordy,
                        input bit e_ov, e_ir, input int e_cnt, input logic [31:0] e_pc, e_inst);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt; v.e_pc = e_pc; v.e_inst = e_inst;
        tbl.push_back(v);
    endtask

    task automatic idle();
        rst = 1'b1; flush = 1'b0;
        qi.in_valid = 1'b0; qi.in_pc = '0; qi.in_inst = '0; qi.out_ready = 1'b0;
    endtask

    // One clock: drive, compare against the model before the edge, then advance the model.
    task automatic cyc(input bit r, f, iv, input logic [31:0] pc, inst, input bit ordy);
        int sz;
        bit e_ov, e_ir, take, pop, acc;
        logic [31:0] e_pc, e_inst;
        rst = r; flush = f; qi.in_valid = iv; qi.in_pc = pc; qi.in_inst = inst; qi.out_ready = ordy;
        #1;
        sz     = mq.size();
        e_ir   = (sz != DEPTH);
        e_ov   = (sz != 0);
        e_pc   = (sz != 0) ? mq[0][63:32] : 32'h0;
        e_inst = (sz != 0) ? mq[0][31:0]  : 32'h0;
        if (BYP && sz == 0) begin
            e_ov   = iv & ~f;
            e_pc   = f ? 32'h0 : pc;
            e_inst = f ? 32'h0 : inst;
        end
        chk("model_count",     64'(count),         64'(sz));
        chk("model_in_ready",  64'(qi.in_ready),   64'(e_ir));
        chk("model_out_valid", 64'(qi.out_valid),  64'(e_ov));
        chk("model_out_pc",    64'(qi.out_pc),     64'(e_pc));
        chk("model_out_inst",  64'(qi.out_inst),   64'(e_inst));
        @(posedge clk);
        if (!r || f) begin
            mq.delete();
        end else begin
            take = BYP && sz == 0 && iv && ordy;
            pop  = sz > 0 && ordy;
            acc  = iv && sz < DEPTH && !take;
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back({pc, inst});
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table: state observed after each row's edge with idle inputs.
        addv(0,0,1,32'h80000F00,32'h1,0, 0,1,0,32'h0,32'h0);
        addv(0,0,1,32'h80000F04,32'h2,0, 0,1,0,32'h0,32'h0);
        for (int i = 0; i < 4; i++)
            addv(1,0,1,32'h80000000 + 32'(4*i),32'h00000413 + 32'(i),0,
                 1,(i != 3),i+1,32'h80000000,32'h00000413);
        addv(1,0,1,32'h80000200,32'hDEAD,0, 1,0,4,32'h80000000,32'h00000413);
        for (int i = 1; i <= 3; i++)
            addv(1,0,0,32'h0,32'h0,1, 1,1,4-i,32'h80000000 + 32'(4*i),32'h00000413 + 32'(i));
        addv(1,0,0,32'h0,32'h0,1, 0,1,0,32'h0,32'h0);
        for (int i = 0; i < 3; i++)
            addv(1,0,1,32'h80000010 + 32'(4*i),32'h500 + 32'(i),0, 1,1,i+1,32'h80000010,32'h500);
        addv(1,1,1,32'h80000100,32'h700,1, 0,1,0,32'h0,32'h0);
        addv(1,0,0,32'h0,32'h0,0, 0,1,0,32'h0,32'h0);
        addv(1,0,1,32'h80000020,32'h600,0, 1,1,1,32'h80000020,32'h600);
        addv(1,0,1,32'h80000024,32'h601,1, 1,1,1,32'h80000024,32'h601);
        addv(1,1,1,32'h80000028,32'h602,1, 0,1,0,32'h0,32'h0);

        foreach (tbl[k]) begin
            cyc(tbl[k].r, tbl[k].f, tbl[k].iv, tbl[k].pc, tbl[k].inst, tbl[k].ordy);
            idle();
            #1;
            chk($sformatf("tbl%0d_count", k),     64'(count),        64'(tbl[k].e_cnt));
            chk($sformatf("tbl%0d_in_ready", k),  64'(qi.in_ready),  64'(tbl[k].e_ir));
            chk($sformatf("tbl%0d_out_valid", k), 64'(qi.out_valid), 64'(tbl[k].e_ov));
            chk($sformatf("tbl%0d_out_pc", k),    64'(qi.out_pc),    64'(tbl[k].e_pc));
            chk($sformatf("tbl%0d_out_inst", k),  64'(qi.out_inst),  64'(tbl[k].e_inst));
        end

        // Steady enq+deq at count 2: pointers wrap, output lags input by two entries.
        cyc(0,0,0,32'h0,32'h0,0);
        cyc(1,0,1,32'h80000300,32'h900,0);
        cyc(1,0,1,32'h80000304,32'h901,0);
        for (int k = 0; k < 10; k++) begin
            cyc(1,0,1,32'h80000308 + 32'(4*k),32'h902 + 32'(k),1);
            chk($sformatf("simul%0d_count", k),  64'(count),     64'd2);
            chk($sformatf("simul%0d_head_pc", k), 64'(qi.out_pc), 64'(32'h80000304 + 32'(4*k)));
        end

        // Empty-queue hand-off: same cycle with bypass, one cycle later without.
        idle();
        cyc(0,0,0,32'h0,32'h0,0);
        rst = 1'b1; qi.in_valid = 1'b1; qi.in_pc = 32'h80000000; qi.in_inst = 32'h00100073;
        qi.out_ready = 1'b1;
        #1;
        chk("byp_same_valid", 64'(qi.out_valid), BYP ? 64'd1 : 64'd0);
        chk("byp_same_pc",    64'(qi.out_pc),    BYP ? 64'h80000000 : 64'h0);
        chk("byp_same_inst",  64'(qi.out_inst),  BYP ? 64'h00100073 : 64'h0);
        cyc(1,0,1,32'h80000000,32'h00100073,1);
        idle();
        #1;
        chk("byp_next_count", 64'(count),        BYP ? 64'd0 : 64'd1);
        chk("byp_next_valid", 64'(qi.out_valid), BYP ? 64'd0 : 64'd1);
        chk("byp_next_pc",    64'(qi.out_pc),    BYP ? 64'h0 : 64'h80000000);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) < 6),
                $urandom(), $urandom(),
                ($urandom_range(0, 9) < 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
